// File: rtl/shift_add_mult16.sv
`default_nettype none
// ============================================================================
//  Module      : shift_add_mult16 (with helper adder16)
//  Description : Sequential unsigned 16x16 -> 32-bit shift-and-add multiplier.
//                One adder16 step per cycle, 16 steps per product. Operands
//                enter on a valid/ready handshake; the product leaves on a
//                second valid/ready handshake with unbounded backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================

// 16-bit unsigned adder with carry out; the multiplier's only arithmetic unit.
module adder16 (
    input  logic [15:0] in0,
    input  logic [15:0] in1,
    output logic [15:0] out,
    output logic        c_out
);

    // Widen by one bit so the carry lands in the MSB of the sum
    assign {c_out, out} = {1'b0, in0} + {1'b0, in1};

endmodule

module shift_add_mult16 #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [3:0]         r_count;
    logic [WIDTH-1:0]   r_acc_hi;
    logic [WIDTH-1:0]   r_acc_lo;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_product;

    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH-1:0]   w_sum;
    logic               w_carry;
    logic [WIDTH-1:0]   w_next_hi;
    logic [WIDTH-1:0]   w_next_lo;

    // Multiplier LSB selects whether the multiplicand is added this step
    assign w_addend = r_acc_lo[0] ? r_mcand : '0;

    adder16 u_adder (
        .in0   (r_acc_hi),
        .in1   (w_addend),
        .out   (w_sum),
        .c_out (w_carry)
    );

    // Post-step partial product: the carry always shifts in at the top and
    // the consumed multiplier bit falls off the bottom.
    assign w_next_hi = {w_carry, w_sum[WIDTH-1:1]};
    assign w_next_lo = {w_sum[0], r_acc_lo[WIDTH-1:1]};

    // Handshake and status flags are pure decodes of the state
    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state == S_BUSY);
    assign out_valid = (r_state == S_DONE);
    assign product   = r_product;

    // Control FSM plus datapath registers; reset aborts any in-flight product
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_count   <= 4'd0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_mcand   <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mcand  <= a;
                        r_acc_lo <= b;
                        r_acc_hi <= '0;
                        r_count  <= 4'd0;
                        r_state  <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_acc_hi <= w_next_hi;
                    r_acc_lo <= w_next_lo;
                    // 4-bit counter wraps back to 0 on the final step
                    r_count  <= r_count + 4'd1;
                    if (r_count == 4'd15) begin
                        r_product <= {w_next_hi, w_next_lo};
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mult16.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_add_mult16
//  Description : Self-checking bench for shift_add_mult16 using a product
//                scoreboard queue filled at acceptance and drained at output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_add_mult16;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;
    logic        busy;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    shift_add_mult16 #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Advance one clock; everything is sampled and driven 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands for one accepting edge and record the reference product
    task automatic accept(input logic [15:0] ta, input logic [15:0] tb);
        a        = ta;
        b        = tb;
        in_valid = 1'b1;
        exp_q.push_back({16'h0, ta} * {16'h0, tb});
        tick();
        in_valid = 1'b0;
    endtask

    // Count cycles until out_valid, bounded so a stuck DUT cannot hang the run
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a         = 16'hFFFF;
        b         = 16'hFFFF;
        tick();
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        n_vec++;
        if ({in_ready, out_valid, busy} !== 3'b100 || product !== 32'h0) begin
            $display("FAIL reset_state: rdy/vld/busy=%b%b%b product=%h, required 100 / 00000000",
                     in_ready, out_valid, busy, product);
            n_err++;
        end
    endtask

    task automatic test_basic();
        int cyc;
        out_ready = 1'b1;
        accept(16'd3, 16'd5);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            n_vec++;
            if (busy !== 1'b1) begin
                $display("FAIL basic_busy: cycle %0d busy=%b, required 1", cyc, busy);
                n_err++;
            end
            tick();
            cyc++;
        end
        n_vec++;
        if (cyc !== 16) begin
            $display("FAIL basic_latency: %0d cycles, required 16", cyc);
            n_err++;
        end
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        n_vec++;
        if (product !== exp_v || busy !== 1'b0) begin
            $display("FAIL basic_product: product=%h busy=%b, required %h busy=0", product, busy, exp_v);
            n_err++;
        end
        tick();
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL basic_return_idle: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
            n_err++;
        end
    endtask

    task automatic test_corners();
        int lat;
        logic [15:0] ta[2] = '{16'hFFFF, 16'h1234};
        logic [15:0] tb[2] = '{16'hFFFF, 16'h0000};
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            accept(ta[i], tb[i]);
            wait_done(lat);
            exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
            n_vec++;
            if (lat !== 16 || product !== exp_v) begin
                $display("FAIL corner_%0d: latency=%0d product=%h, required 16 / %h", i, lat, product, exp_v);
                n_err++;
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        accept(16'h00FF, 16'h0100);
        wait_done(lat);
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        n_vec++;
        if (lat !== 16) begin
            $display("FAIL bp_latency: %0d cycles, required 16", lat);
            n_err++;
        end
        for (int i = 0; i < 5; i++) begin
            n_vec++;
            if (out_valid !== 1'b1 || product !== exp_v || in_ready !== 1'b0) begin
                $display("FAIL bp_hold_%0d: out_valid=%b product=%h in_ready=%b, required 1 / %h / 0",
                         i, out_valid, product, in_ready, exp_v);
                n_err++;
            end
            // Offer new operands in the final DONE cycle together with out_ready
            if (i == 4) begin
                a         = 16'd7;
                b         = 16'd9;
                in_valid  = 1'b1;
                out_ready = 1'b1;
            end
            tick();
        end
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL bp_release: rdy/vld/busy=%b%b%b, required 100", in_ready, out_valid, busy);
            n_err++;
        end
        // The waiting operands are taken on the IDLE edge that follows
        accept(16'd7, 16'd9);
        wait_done(lat);
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        n_vec++;
        if (lat !== 16 || product !== exp_v) begin
            $display("FAIL bp_deferred_accept: latency=%0d product=%h, required 16 / %h", lat, product, exp_v);
            n_err++;
        end
        tick();
    endtask

    task automatic test_reset_midop();
        int lat;
        out_ready = 1'b1;
        a         = 16'hABCD;
        b         = 16'h1357;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        n_vec++;
        if (busy !== 1'b1) begin
            $display("FAIL midop_busy: busy=%b, required 1", busy);
            n_err++;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++;
        if ({in_ready, out_valid, busy} !== 3'b100 || product !== 32'h0) begin
            $display("FAIL midop_reset: rdy/vld/busy=%b%b%b product=%h, required 100 / 00000000",
                     in_ready, out_valid, busy, product);
            n_err++;
        end
        accept(16'h1234, 16'h0010);
        wait_done(lat);
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        n_vec++;
        if (lat !== 16 || product !== exp_v) begin
            $display("FAIL midop_after_reset: latency=%0d product=%h, required 16 / %h", lat, product, exp_v);
            n_err++;
        end
        tick();
    endtask

    // in_valid stays high with fresh operands every cycle; accepts land every 18 cycles
    task automatic test_back_to_back();
        logic exp_rdy;
        logic exp_vld;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 3 * 18; k++) begin
            exp_rdy = ((k % 18) == 0);
            exp_vld = ((k % 18) == 17);
            a = 16'($urandom);
            b = 16'($urandom);
            n_vec++;
            if (in_ready !== exp_rdy || out_valid !== exp_vld) begin
                $display("FAIL b2b_cycle_%0d: in_ready=%b out_valid=%b, required %b / %b",
                         k, in_ready, out_valid, exp_rdy, exp_vld);
                n_err++;
            end
            if (exp_rdy) begin
                exp_q.push_back({16'h0, a} * {16'h0, b});
            end
            if (exp_vld) begin
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
                n_vec++;
                if (product !== exp_v) begin
                    $display("FAIL b2b_product_%0d: product=%h, required %h", k, product, exp_v);
                    n_err++;
                end
            end
            tick();
        end
        in_valid = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 16'h0;
        b         = 16'h0;
        test_reset();
        test_basic();
        test_corners();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
